// File: rtl/mini_exec_datapath_if.sv
// Host-side bundle for mini_exec_datapath: program/register load, debug read, execution status.
// The master modport is the host/test controller; the slave modport is the datapath.
interface mini_exec_datapath_if;
    logic        start;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic [3:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] wdata;
    logic        wr_valid;
    logic        cout;
    logic [31:0] prod_hi;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;

    modport master (
        output start, imem_we, imem_waddr, imem_wdata,
        output reg_we, reg_waddr, reg_wdata, dbg_raddr,
        input  dbg_rdata, wdata, wr_valid, cout, prod_hi, pc, busy, halted
    );

    modport slave (
        input  start, imem_we, imem_waddr, imem_wdata,
        input  reg_we, reg_waddr, reg_wdata, dbg_raddr,
        output dbg_rdata, wdata, wr_valid, cout, prod_hi, pc, busy, halted
    );
endinterface

// File: rtl/mini_exec_datapath.sv
// Sequenced execution datapath: imem + regfile + ALU, 5 cycles/instruction, host load/seed/debug.
// Optional macro ALU_MUL_EN enables op 9 as 64-bit unsigned multiply; otherwise op 9 is a NOP.
module mini_exec_datapath #(
    parameter int IMEM_DEPTH = 32,
    parameter int NREGS      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mini_exec_datapath_if.slave  bus
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_EXECUTE, S_WRITE, S_HALTED
    } state_t;

    state_t state_q, state_d;

    logic [15:0]   imem_mem [IMEM_DEPTH];
    logic [31:0]   regs_q   [NREGS];
    logic [AW-1:0] pc_q;
    logic [15:0]   ir_q;
    logic [3:0]    op_q;
    logic [RW-1:0] rs2_q, rs1_q, rd_q;
    logic [31:0]   a_q, b_q;
    logic [63:0]   res_q;
    logic          carry_q;
    logic [31:0]   wdata_q, prod_hi_q;
    logic          cout_q;

    logic [63:0]   alu_res;
    logic          alu_c;
    logic [32:0]   tmp33;
    logic          busy;
    logic          wr_commit;
    logic          start_ok;

    assign busy     = (state_q != S_IDLE) && (state_q != S_HALTED);
    assign start_ok = !busy && bus.start;

`ifdef ALU_MUL_EN
    assign wr_commit = (state_q == S_WRITE);
`else
    // Without the multiplier, op 9 walks the pipeline but commits nothing.
    assign wr_commit = (state_q == S_WRITE) && (op_q != 4'h9);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HALTED: if (bus.start) state_d = S_FETCH;
            S_FETCH:   state_d = S_DECODE;
            S_DECODE:  state_d = (ir_q[15:12] == 4'hF) ? S_HALTED : S_OPERAND;
            S_OPERAND: state_d = S_EXECUTE;
            S_EXECUTE: state_d = S_WRITE;
            S_WRITE:   state_d = S_FETCH;
            default:   state_d = S_IDLE;
        endcase
    end

    // Ops that leave the carry alone fall through with the current flag.
    always_comb begin
        alu_res = '0;
        alu_c   = cout_q;
        tmp33   = '0;
        case (op_q)
            4'h0: begin
                tmp33         = {1'b0, a_q} + {1'b0, b_q};
                alu_res[31:0] = tmp33[31:0];
                alu_c         = tmp33[32];
            end
            4'h1: begin
                tmp33         = {1'b0, a_q} - {1'b0, b_q};
                alu_res[31:0] = tmp33[31:0];
                alu_c         = ~tmp33[32];
            end
            4'h2: alu_res[31:0] = a_q & b_q;
            4'h3: alu_res[31:0] = a_q | b_q;
            4'h4: alu_res[31:0] = a_q ^ b_q;
            4'h5: alu_res[31:0] = ~a_q;
            4'h6: alu_res[31:0] = a_q << b_q[4:0];
            4'h7: alu_res[31:0] = a_q >> b_q[4:0];
            4'h8: alu_res[31:0] = $signed(a_q) >>> b_q[4:0];
`ifdef ALU_MUL_EN
            4'h9: alu_res = {32'b0, a_q} * {32'b0, b_q};
`else
            4'h9: alu_res = '0;
`endif
            4'hA: begin
                tmp33         = {1'b0, a_q} + 33'd1;
                alu_res[31:0] = tmp33[31:0];
                alu_c         = tmp33[32];
            end
            4'hB: alu_res[31:0] = a_q - 32'd1;
            4'hC: alu_res[31:0] = {31'b0, ($signed(a_q) < $signed(b_q))};
            4'hD: alu_res[31:0] = a_q;
            4'hE: begin
                tmp33         = {1'b0, a_q} + {1'b0, b_q} + {32'b0, cout_q};
                alu_res[31:0] = tmp33[31:0];
                alu_c         = tmp33[32];
            end
            default: alu_res = '0;
        endcase
    end

    // Instruction memory survives reset so programs stay loaded.
    always_ff @(posedge clk) begin
        if (bus.imem_we) imem_mem[bus.imem_waddr] <= bus.imem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= '0;
            ir_q      <= '0;
            op_q      <= '0;
            rs2_q     <= '0;
            rs1_q     <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            wdata_q   <= '0;
            prod_hi_q <= '0;
            cout_q    <= 1'b0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (start_ok) pc_q <= '0;
            case (state_q)
                S_FETCH: begin
                    ir_q <= imem_mem[pc_q];
                    pc_q <= pc_q + 1'b1;
                end
                S_DECODE: begin
                    op_q  <= ir_q[15:12];
                    rs2_q <= ir_q[11:8];
                    rs1_q <= ir_q[7:4];
                    rd_q  <= ir_q[3:0];
                end
                S_OPERAND: begin
                    a_q <= regs_q[rs2_q];
                    b_q <= regs_q[rs1_q];
                end
                S_EXECUTE: begin
                    res_q   <= alu_res;
                    carry_q <= alu_c;
                end
                default: ;
            endcase
            if (wr_commit) begin
                regs_q[rd_q] <= res_q[31:0];
                wdata_q      <= res_q[31:0];
                prod_hi_q    <= res_q[63:32];
                cout_q       <= carry_q;
            end else if (bus.reg_we && !busy) begin
                regs_q[bus.reg_waddr] <= bus.reg_wdata;
            end
        end
    end

    assign bus.dbg_rdata = regs_q[bus.dbg_raddr];
    assign bus.wdata     = wdata_q;
    assign bus.wr_valid  = wr_commit;
    assign bus.cout      = cout_q;
    assign bus.prod_hi   = prod_hi_q;
    assign bus.pc        = pc_q;
    assign bus.busy      = busy;
    assign bus.halted    = (state_q == S_HALTED);
endmodule

// File: tb/tb_mini_exec_datapath.sv
// Directed self-checking bench for mini_exec_datapath; all driving and sampling on the falling edge.
module tb_mini_exec_datapath;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mini_exec_datapath_if bus ();

    mini_exec_datapath #(.IMEM_DEPTH(32), .NREGS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] wd_log [$];
    logic        c_log  [$];
    logic [31:0] ph_log [$];

    // Capture architectural outputs the cycle after each writeback pulse.
    always @(negedge clk) begin
        if (bus.wr_valid === 1'b1) begin
            @(negedge clk);
            wd_log.push_back(bus.wdata);
            c_log.push_back(bus.cout);
            ph_log.push_back(bus.prod_hi);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rs2,
                                        input logic [3:0] rs1, input logic [3:0] rd);
        return {op, rs2, rs1, rd};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wd_log.delete(); c_log.delete(); ph_log.delete();
    endtask

    task automatic set_reg(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.reg_we = 1'b1; bus.reg_waddr = a; bus.reg_wdata = v;
        @(negedge clk);
        bus.reg_we = 1'b0;
    endtask

    task automatic load_imem(input logic [4:0] a, input logic [15:0] w);
        @(negedge clk);
        bus.imem_we = 1'b1; bus.imem_waddr = a; bus.imem_wdata = w;
        @(negedge clk);
        bus.imem_we = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        bus.dbg_raddr = a;
        @(negedge clk);
        check_eq(tag, {32'b0, bus.dbg_rdata}, {32'b0, exp});
    endtask

    // Pulse start; returns in the FETCH cycle of the first instruction.
    task automatic kick();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (bus.halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("halted", {63'b0, bus.halted}, 64'd1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int prev_pc;
        int wrap_pc;
        bus.start = 0; bus.imem_we = 0; bus.imem_waddr = 0; bus.imem_wdata = 0;
        bus.reg_we = 0; bus.reg_waddr = 0; bus.reg_wdata = 0; bus.dbg_raddr = 0;

        // Reset state
        do_reset();
        check_eq("rst_pc",      {59'b0, bus.pc},       64'd0);
        check_eq("rst_wdata",   {32'b0, bus.wdata},    64'd0);
        check_eq("rst_prod_hi", {32'b0, bus.prod_hi},  64'd0);
        check_eq("rst_cout",    {63'b0, bus.cout},     64'd0);
        check_eq("rst_wr_valid",{63'b0, bus.wr_valid}, 64'd0);
        check_eq("rst_busy",    {63'b0, bus.busy},     64'd0);
        check_eq("rst_halted",  {63'b0, bus.halted},   64'd0);

        // ADD R3 = R2 + R1, latency, host write while busy ignored
        set_reg(4'd1, 32'd5);
        set_reg(4'd2, 32'd7);
        load_imem(5'd0, 16'h0213);
        load_imem(5'd1, 16'hF000);
        kick();
        check_eq("busy_fetch", {63'b0, bus.busy}, 64'd1);
        bus.reg_we = 1'b1; bus.reg_waddr = 4'd6; bus.reg_wdata = 32'h55;
        @(negedge clk);
        bus.reg_we = 1'b0;
        cnt = 1;
        while (bus.wr_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("wr_valid_latency", cnt, 64'd4);
        wait_halt(50);
        check_eq("add_wdata", {32'b0, bus.wdata}, 64'd12);
        check_eq("add_cout",  {63'b0, bus.cout},  64'd0);
        check_eq("halt_pc",   {59'b0, bus.pc},    64'd2);
        check_eq("halt_busy", {63'b0, bus.busy},  64'd0);
        check_reg("add_r3", 4'd3, 32'd12);
        check_reg("busy_reg_we_ignored", 4'd6, 32'd0);

        // ADD then ADC carry chain
        do_reset();
        set_reg(4'd1, 32'd1);
        set_reg(4'd2, 32'hFFFF_FFFF);
        load_imem(5'd0, ins(4'h0, 4'd2, 4'd1, 4'd3));
        load_imem(5'd1, ins(4'hE, 4'd2, 4'd1, 4'd4));
        load_imem(5'd2, 16'hF000);
        kick();
        wait_halt(60);
        @(negedge clk);
        check_eq("carry_nlog", wd_log.size(), 64'd2);
        if (wd_log.size() == 2) begin
            check_eq("add_wrap_wdata", {32'b0, wd_log[0]}, 64'd0);
            check_eq("add_wrap_cout",  {63'b0, c_log[0]},  64'd1);
            check_eq("adc_wdata",      {32'b0, wd_log[1]}, 64'd1);
            check_eq("adc_cout",       {63'b0, c_log[1]},  64'd1);
        end
        check_reg("add_wrap_r3", 4'd3, 32'd0);
        check_reg("adc_r4",      4'd4, 32'd1);

        // Shifts and the remaining ALU ops with A=R2=80000000, B=R1=4
        do_reset();
        set_reg(4'd1, 32'd4);
        set_reg(4'd2, 32'h8000_0000);
        load_imem(5'd0,  ins(4'h6, 4'd2, 4'd1, 4'd5));
        load_imem(5'd1,  ins(4'h7, 4'd2, 4'd1, 4'd6));
        load_imem(5'd2,  ins(4'h8, 4'd2, 4'd1, 4'd7));
        load_imem(5'd3,  ins(4'h1, 4'd2, 4'd1, 4'd8));
        load_imem(5'd4,  ins(4'hC, 4'd2, 4'd1, 4'd9));
        load_imem(5'd5,  ins(4'h4, 4'd2, 4'd1, 4'd10));
        load_imem(5'd6,  ins(4'h5, 4'd2, 4'd1, 4'd11));
        load_imem(5'd7,  ins(4'hD, 4'd2, 4'd1, 4'd12));
        load_imem(5'd8,  ins(4'hA, 4'd2, 4'd1, 4'd13));
        load_imem(5'd9,  ins(4'hB, 4'd2, 4'd1, 4'd14));
        load_imem(5'd10, ins(4'h2, 4'd2, 4'd1, 4'd15));
        load_imem(5'd11, ins(4'h3, 4'd2, 4'd1, 4'd3));
        load_imem(5'd12, 16'hF000);
        kick();
        wait_halt(200);
        @(negedge clk);
        check_reg("shl", 4'd5,  32'h0000_0000);
        check_reg("shr", 4'd6,  32'h0800_0000);
        check_reg("sra", 4'd7,  32'hF800_0000);
        check_reg("sub", 4'd8,  32'h7FFF_FFFC);
        check_reg("slt", 4'd9,  32'd1);
        check_reg("xor", 4'd10, 32'h8000_0004);
        check_reg("not", 4'd11, 32'h7FFF_FFFF);
        check_reg("mov", 4'd12, 32'h8000_0000);
        check_reg("inc", 4'd13, 32'h8000_0001);
        check_reg("dec", 4'd14, 32'h7FFF_FFFF);
        check_reg("and", 4'd15, 32'h0000_0000);
        check_reg("or",  4'd3,  32'h8000_0004);
        check_eq("alu_nlog", wd_log.size(), 64'd12);
        if (c_log.size() > 4) begin
            check_eq("sub_cout",   {63'b0, c_log[3]}, 64'd1);
            check_eq("shift_cout", {63'b0, c_log[0]}, 64'd0);
        end
        check_eq("inc_cout_final", {63'b0, bus.cout}, 64'd0);

        // Op 9: multiply or NOP depending on build
        do_reset();
        set_reg(4'd1, 32'h0001_0000);
        set_reg(4'd2, 32'h0001_0000);
        set_reg(4'd3, 32'h0000_DEAD);
        load_imem(5'd0, ins(4'h0, 4'd2, 4'd1, 4'd4));
        load_imem(5'd1, ins(4'h9, 4'd2, 4'd1, 4'd3));
        load_imem(5'd2, 16'hF000);
        kick();
        wait_halt(60);
        @(negedge clk);
        check_reg("mul_pre_add", 4'd4, 32'h0002_0000);
`ifdef ALU_MUL_EN
        check_eq("mul_nwr",     wd_log.size(), 64'd2);
        check_eq("mul_wdata",   {32'b0, bus.wdata},   64'd0);
        check_eq("mul_prod_hi", {32'b0, bus.prod_hi}, 64'd1);
        check_reg("mul_r3", 4'd3, 32'd0);
`else
        check_eq("nop_nwr",     wd_log.size(), 64'd1);
        check_eq("nop_wdata",   {32'b0, bus.wdata},   64'h2_0000);
        check_eq("nop_prod_hi", {32'b0, bus.prod_hi}, 64'd0);
        check_reg("nop_r3", 4'd3, 32'h0000_DEAD);
`endif
        check_eq("op9_cout", {63'b0, bus.cout}, 64'd0);

        // Reset in EXECUTE aborts with no writeback; imem survives
        do_reset();
        load_imem(5'd0, 16'h0213);
        load_imem(5'd1, 16'hF000);
        set_reg(4'd1, 32'd5);
        set_reg(4'd2, 32'd7);
        kick();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort_busy", {63'b0, bus.busy}, 64'd0);
        check_eq("abort_pc",   {59'b0, bus.pc},   64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("abort_no_wr", wd_log.size(), 64'd0);
        check_reg("abort_r1", 4'd1, 32'd0);
        check_reg("abort_r3", 4'd3, 32'd0);
        wd_log.delete(); c_log.delete(); ph_log.delete();
        set_reg(4'd1, 32'd5);
        set_reg(4'd2, 32'd7);
        kick();
        wait_halt(50);
        check_reg("imem_kept_r3", 4'd3, 32'd12);

        // 32 MOVs, no HALT: pc wraps and fetching continues
        do_reset();
        for (int i = 0; i < 32; i++) load_imem(5'(i), ins(4'hD, 4'd1, 4'd0, 4'd2));
        set_reg(4'd1, 32'h0000_0ABC);
        kick();
        wd_log.delete();
        prev_pc = -1;
        wrap_pc = -1;
        cnt = 0;
        while (wd_log.size() < 33 && cnt < 400) begin
            @(negedge clk);
            cnt++;
            if (prev_pc == 31 && int'(bus.pc) != 31 && wrap_pc < 0) wrap_pc = int'(bus.pc);
            prev_pc = int'(bus.pc);
        end
        check_eq("wrap_nwr",    wd_log.size(), 64'd33);
        check_eq("wrap_pc",     64'(wrap_pc), 64'd0);
        check_eq("wrap_busy",   {63'b0, bus.busy},   64'd1);
        check_eq("wrap_halted", {63'b0, bus.halted}, 64'd0);
        check_eq("wrap_wdata",  {32'b0, bus.wdata},  64'h0ABC);
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
